// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM macro initiator.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_WORDS  = 32;

endpackage

// File: rtl/sram_ctrl_rsp_reg.sv
// Response holding register: loaded with one beat, held until the consumer
// takes it, then cleared back to zero.
module sram_ctrl_rsp_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_rdata,
    input  logic              load_err,
    input  logic              clear,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    // Load has priority over clear; the FSM never asserts both together.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (load) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_rdata;
            resp_err   <= load_err;
        end else if (clear) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_macro_ctrl.sv
// Single-port SRAM macro initiator: turns a valid/ready request stream into
// registered A/CSB/WEB/OEB/I pin activity and returns read data on a
// response stream. One operation in flight at a time.
// Optional build macro SRAM_CTRL_WACK_EN: each write also returns an ack beat.
module sram_macro_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);

    state_t            state;
    logic              op_wr;
    logic              accept;
    logic              addr_ok;
    logic              rsp_load;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_clear;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    // Out-of-range addresses are answered locally and never reach the macro.
    assign addr_ok   = ({1'b0, req_addr} < WORDS_L);

    // Response beat sources: local error, read data in RD_WAIT, optional write ack.
    always_comb begin
        rsp_load  = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                rsp_load = accept && !addr_ok;
                rsp_err  = 1'b1;
            end
`ifdef SRAM_CTRL_WACK_EN
            ACCESS:  rsp_load = op_wr;
`endif
            RD_WAIT: begin
                rsp_load  = 1'b1;
                rsp_rdata = sram_o;
            end
            default: ;
        endcase
        rsp_clear = (state == RESP) && resp_ready;
    end

    // Sequencer: owns every macro pin register, so nothing from req_* reaches
    // the pins combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            sram_a   <= '0;
            sram_i   <= '0;
            sram_csb <= 1'b1;
            sram_web <= 1'b1;
            sram_oeb <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (addr_ok) begin
                            sram_a   <= req_addr;
                            sram_i   <= req_wdata;
                            sram_csb <= 1'b0;
                            sram_web <= ~req_write;
                            op_wr    <= req_write;
                            state    <= ACCESS;
                        end else begin
                            state    <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Macro captures the access on this edge.
                    sram_csb <= 1'b1;
                    sram_web <= 1'b1;
                    if (op_wr) begin
`ifdef SRAM_CTRL_WACK_EN
                        state <= RESP;
`else
                        state <= IDLE;
`endif
                    end else begin
                        sram_oeb <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    sram_oeb <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_ctrl_rsp_reg #(.DATA_W(DATA_W)) u_rsp (
        .clock      (clock),
        .reset      (reset),
        .load       (rsp_load),
        .load_rdata (rsp_rdata),
        .load_err   (rsp_err),
        .clear      (rsp_clear),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

endmodule

// File: tb/tb_sram_macro_ctrl.sv
// Bench for sram_macro_ctrl: behavioural macro model, scoreboard queue and
// a word-array reference model. Second instance covers WORDS=24 errors.
module tb_sram_macro_ctrl;

    localparam int AW = 5;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, resp_valid, resp_err;
    logic [DW-1:0] resp_rdata, sram_i, sram_o;
    logic [AW-1:0] sram_a;
    logic          sram_csb, sram_web, sram_oeb;

    // WORDS=24 instance
    logic          q2_valid = 1'b0, q2_write = 1'b0, r2_ready = 1'b1;
    logic [AW-1:0] q2_addr = '0;
    logic          q2_ready, r2_valid, r2_err, s2_csb, s2_web, s2_oeb;
    logic [DW-1:0] r2_rdata, s2_i;
    logic [AW-1:0] s2_a;
    logic [DW-1:0] s2_o = {DW{1'b1}};

    always #5 clock = ~clock;

    sram_macro_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORDS(32)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sram_a(sram_a), .sram_csb(sram_csb), .sram_web(sram_web),
        .sram_oeb(sram_oeb), .sram_i(sram_i), .sram_o(sram_o));

    sram_macro_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORDS(24)) u_dut24 (
        .clock(clock), .reset(reset),
        .req_valid(q2_valid), .req_ready(q2_ready), .req_write(q2_write),
        .req_addr(q2_addr), .req_wdata({DW{1'b1}}),
        .resp_valid(r2_valid), .resp_ready(r2_ready),
        .resp_rdata(r2_rdata), .resp_err(r2_err),
        .sram_a(s2_a), .sram_csb(s2_csb), .sram_web(s2_web),
        .sram_oeb(s2_oeb), .sram_i(s2_i), .sram_o(s2_o));

    // Behavioural single-port macro, CE = clock
    logic [DW-1:0] macro_mem [0:31];
    logic [DW-1:0] macro_q = '0;
    initial for (int k = 0; k < 32; k++) macro_mem[k] = '0;
    always @(posedge clock) begin
        if (!sram_csb) begin
            if (!sram_web) macro_mem[sram_a] <= sram_i;
            else           macro_q <= macro_mem[sram_a];
        end
    end
    assign sram_o = sram_oeb ? {DW{1'bx}} : macro_q;

    // Reference model and scoreboard
    typedef struct { logic [DW-1:0] rdata; logic err; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:31];
    initial for (int k = 0; k < 32; k++) ref_mem[k] = '0;

`ifdef SRAM_CTRL_WACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    int checks = 0, passed = 0, beats = 0, cyc = 0, acc_cyc = 0;
    bit rand_rdy = 1'b0;
    bit csb2_low = 1'b0;

    always @(posedge clock) cyc++;
    always @(posedge clock) if (!s2_csb) csb2_low = 1'b1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        checks++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Monitor: pops one expectation per consumed response beat
    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            exp_t e;
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: rdata %h err %b with empty queue", resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {63'b0, resp_err}, {63'b0, e.err});
            end
        end
    end

    // Random consumer backpressure
    always @(posedge clock) if (rand_rdy) #2 resp_ready = 1'($urandom_range(0, 1));

    // Offer one request, push its expectation, return #1 after the accept edge
    task automatic do_req(input bit wr, input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit push);
        int n = 0;
        exp_t e;
        req_valid = 1'b1; req_write = wr; req_addr = ad; req_wdata = d;
        @(negedge clock);
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        if (!req_ready) begin
            fail_now("req_ready_wait");
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            if (wr) begin
                ref_mem[ad] = d;
                if (WACK) begin e.rdata = '0; e.err = 1'b0; exp_q.push_back(e); end
            end else begin
                e.rdata = ref_mem[ad]; e.err = 1'b0; exp_q.push_back(e);
            end
        end
        @(posedge clock); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 500) begin @(posedge clock); n++; end
        if (exp_q.size() != 0) fail_now("drain");
        #1;
    endtask

    task automatic req24(input bit wr, input logic [AW-1:0] ad, input logic [DW-1:0] er, input logic ee);
        int n = 0;
        q2_valid = 1'b1; q2_write = wr; q2_addr = ad;
        @(negedge clock);
        while (!q2_ready && n < 100) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        q2_valid = 1'b0;
        n = 0;
        while (!r2_valid && n < 20) begin @(posedge clock); #1; n++; end
        if (!r2_valid) fail_now("dut24_resp");
        else begin
            chk("dut24_rdata", r2_rdata, er);
            chk("dut24_err", {63'b0, r2_err}, {63'b0, ee});
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int prev;
        int b0;
        bit hold_ok;
        logic [DW-1:0] held;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("ready_in_reset", {63'b0, req_ready}, 64'd0);
        @(posedge clock); #1;
        chk("rst_pins", {sram_csb, sram_web, sram_oeb, resp_valid, resp_err}, {59'b0, 5'b11100});
        chk("rst_a_i", {sram_a, sram_i[7:0]}, '0);
        chk("rst_rdata", resp_rdata, '0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {63'b0, req_ready}, 64'd1);

        // Write then read addr 5, with read latency
        do_req(1'b1, 5'd5, 64'hDEADBEEF_01234567, 1'b1);
        drain();
        do_req(1'b0, 5'd5, '0, 1'b1);           // #1 after accept edge E0
        @(posedge clock); #1;                  // E1
        chk("rd_lat_e1", {63'b0, resp_valid}, 64'd0);
        @(posedge clock); #1;                  // E2: third edge counting accept
        chk("rd_lat_e2", {63'b0, resp_valid}, 64'd1);
        drain();

        // Boundary addresses
        do_req(1'b1, 5'd0,  64'hA5A5_0000_0000_5A5A, 1'b1);
        do_req(1'b1, 5'd31, 64'h1357_9BDF_2468_ACE0, 1'b1);
        do_req(1'b0, 5'd0,  '0, 1'b1);
        do_req(1'b0, 5'd31, '0, 1'b1);
        do_req(1'b0, 5'd5,  '0, 1'b1);
        drain();

        // Backpressure hold for 10 cycles
        resp_ready = 1'b0;
        do_req(1'b0, 5'd31, '0, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        held = resp_rdata;
        hold_ok = resp_valid;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (!resp_valid || resp_rdata !== held || req_ready) hold_ok = 1'b0;
        end
        chk("hold_stable", {63'b0, hold_ok}, 64'd1);
        chk("hold_data", held, 64'h1357_9BDF_2468_ACE0);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd0;
        @(posedge clock); #1;                  // handshake edge
        chk("ready_after_hs", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b0;
        do_req(1'b0, 5'd0, '0, 1'b1);
        drain();

        // Reset during RD_WAIT abandons the read
        do_req(1'b0, 5'd31, '0, 1'b0);
        @(posedge clock); #1;
        chk("in_rd_wait_oeb", {63'b0, sram_oeb}, 64'd0);
        reset = 1'b1;
        #1;
        chk("ready_rst_mid", {63'b0, req_ready}, 64'd0);
        @(posedge clock); #1;
        chk("rst_mid_pins", {60'b0, sram_csb, sram_web, sram_oeb, resp_valid}, 64'b1110);
        reset = 1'b0;
        do_req(1'b0, 5'd31, '0, 1'b1);
        drain();

        // Back-to-back writes: beat count and spacing
        b0 = beats;
        do_req(1'b1, 5'd10, 64'h10, 1'b1);
        prev = acc_cyc;
        for (int k = 1; k < 4; k++) begin
            do_req(1'b1, 5'(10 + k), 64'(16 + k), 1'b1);
            if (!WACK) chk("wr_spacing", 64'(acc_cyc - prev), 64'd2);
            prev = acc_cyc;
        end
        repeat (6) @(posedge clock);
        drain();
        chk("wr_beats", 64'(beats - b0), WACK ? 64'd4 : 64'd0);

        // Randomised traffic with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_req(1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b1);
            else
                do_req(1'b0, 5'($urandom_range(0, 31)), '0, 1'b1);
        end
        rand_rdy = 1'b0;
        #3 resp_ready = 1'b1;
        drain();

        // WORDS=24 instance: errors never touch the macro
        csb2_low = 1'b0;
        req24(1'b0, 5'd24, '0, 1'b1);
        req24(1'b1, 5'd31, '0, 1'b1);
        chk("dut24_csb_idle", {63'b0, csb2_low}, 64'd0);
        req24(1'b0, 5'd3, {DW{1'b1}}, 1'b0);
        chk("dut24_csb_legal", {63'b0, csb2_low}, 64'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
